// File: rtl/fpu_scoreboard_pkg.sv
// ============================================================================
// fpu_scoreboard_pkg : shared types and helpers for the FP scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_scoreboard_pkg;

    localparam int SB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_KILL = 2'd2
    } sb_state_e;

    // A source operand collides with the outstanding destination.
    function automatic logic src_hit(input logic       en,
                                     input logic [4:0] addr,
                                     input logic [4:0] pend_addr);
        return en && (addr == pend_addr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_scoreboard_if.sv
// ============================================================================
// fpu_scoreboard_if : decode/execute side signals of the FP scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

interface fpu_scoreboard_if #(
    parameter int CNT_W = 8
);
    logic             issue_valid;
    logic             issue_multi;
    logic             issue_fwren;
    logic [4:0]       issue_waddr;
    logic             issue_frden1;
    logic             issue_frden2;
    logic             issue_frden3;
    logic [4:0]       issue_raddr1;
    logic [4:0]       issue_raddr2;
    logic [4:0]       issue_raddr3;
    logic             exe_ready;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             wb_wren;
    logic [4:0]       wb_waddr;
    logic             pend_valid;
    logic [4:0]       pend_waddr;
    logic             timeout_err;
    logic [CNT_W-1:0] last_lat;

    modport master (
        output issue_valid, issue_multi, issue_fwren, issue_waddr,
               issue_frden1, issue_frden2, issue_frden3,
               issue_raddr1, issue_raddr2, issue_raddr3,
               exe_ready, flush,
        input  stall, busy, wb_wren, wb_waddr, pend_valid, pend_waddr,
               timeout_err, last_lat
    );

    modport slave (
        input  issue_valid, issue_multi, issue_fwren, issue_waddr,
               issue_frden1, issue_frden2, issue_frden3,
               issue_raddr1, issue_raddr2, issue_raddr3,
               exe_ready, flush,
        output stall, busy, wb_wren, wb_waddr, pend_valid, pend_waddr,
               timeout_err, last_lat
    );

endinterface

`default_nettype wire

// File: rtl/fpu_scoreboard.sv
// ============================================================================
// fpu_scoreboard : hazard/occupancy tracker for the single multi-cycle FP op
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_scoreboard
    import fpu_scoreboard_pkg::*;
#(
    parameter int TIMEOUT = SB_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    fpu_scoreboard_if.slave   sb
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(TIMEOUT - 1);

    sb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [4:0]       pend_waddr_q, pend_waddr_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;

    logic             w_raw;
    logic             w_waw;
    logic             w_struct;
    logic             w_stall;
    logic             w_accept;
    logic             w_wdog;
    logic             w_wb_wren;
    logic [CNT_W-1:0] w_cnt_inc;

    // Hazards look only at registered state so stall never depends on exe_ready.
    assign w_raw = pend_valid_q &
                   (src_hit(sb.issue_frden1, sb.issue_raddr1, pend_waddr_q) |
                    src_hit(sb.issue_frden2, sb.issue_raddr2, pend_waddr_q) |
                    src_hit(sb.issue_frden3, sb.issue_raddr3, pend_waddr_q));
    assign w_waw    = pend_valid_q & sb.issue_fwren & (sb.issue_waddr == pend_waddr_q);
    assign w_struct = (state_q != SB_IDLE) & sb.issue_multi;
    assign w_stall  = sb.issue_valid & (w_raw | w_waw | w_struct);

    assign w_accept  = sb.issue_valid & sb.issue_multi & ~w_stall & ~sb.flush;
    assign w_wdog    = (cnt_q == c_wdog_last) & ~sb.exe_ready;
    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= SB_IDLE;
            cnt_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_waddr_q  <= 5'd0;
            timeout_err_q <= 1'b0;
            last_lat_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_waddr_q  <= pend_waddr_d;
            timeout_err_q <= timeout_err_d;
            last_lat_q    <= last_lat_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_waddr_d  = pend_waddr_q;
        timeout_err_d = timeout_err_q;
        last_lat_d    = last_lat_q;
        w_wb_wren     = 1'b0;

        case (state_q)
            SB_IDLE: begin
                if (w_accept) begin
                    state_d      = SB_BUSY;
                    cnt_d        = '0;
                    pend_valid_d = sb.issue_fwren;
                    pend_waddr_d = sb.issue_waddr;
                end
            end
            SB_BUSY: begin
                cnt_d = w_cnt_inc;
                // Completion beats a same-cycle flush: the op predates the kill.
                if (sb.exe_ready) begin
                    w_wb_wren    = pend_valid_q;
                    last_lat_d   = w_cnt_inc;
                    pend_valid_d = 1'b0;
                    state_d      = SB_IDLE;
                end else if (w_wdog) begin
                    timeout_err_d = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = SB_IDLE;
                end else if (sb.flush) begin
                    pend_valid_d = 1'b0;
                    state_d      = SB_KILL;
                end
            end
            SB_KILL: begin
                cnt_d = w_cnt_inc;
                if (sb.exe_ready) begin
                    state_d = SB_IDLE;
                end else if (w_wdog) begin
                    timeout_err_d = 1'b1;
                    state_d       = SB_IDLE;
                end
            end
            default: begin
                state_d      = SB_IDLE;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    assign sb.stall       = w_stall;
    assign sb.busy        = (state_q != SB_IDLE);
    assign sb.wb_wren     = w_wb_wren;
    assign sb.wb_waddr    = pend_waddr_q;
    assign sb.pend_valid  = pend_valid_q;
    assign sb.pend_waddr  = pend_waddr_q;
    assign sb.timeout_err = timeout_err_q;
    assign sb.last_lat    = last_lat_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_scoreboard.sv
// ============================================================================
// tb_fpu_scoreboard : directed self-checking bench for fpu_scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpu_scoreboard;
    import fpu_scoreboard_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    fpu_scoreboard_if #(.CNT_W(8)) sb1 ();
    fpu_scoreboard_if #(.CNT_W(8)) sb2 ();

    fpu_scoreboard #(.TIMEOUT(64), .CNT_W(8)) u_dut  (.clock(clock), .reset(reset), .sb(sb1.slave));
    fpu_scoreboard #(.TIMEOUT(8),  .CNT_W(8)) u_dut8 (.clock(clock), .reset(reset), .sb(sb2.slave));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        sb1.issue_valid = 0; sb1.issue_multi = 0; sb1.issue_fwren = 0; sb1.issue_waddr = 0;
        sb1.issue_frden1 = 0; sb1.issue_frden2 = 0; sb1.issue_frden3 = 0;
        sb1.issue_raddr1 = 0; sb1.issue_raddr2 = 0; sb1.issue_raddr3 = 0;
        sb1.exe_ready = 0; sb1.flush = 0;
        sb2.issue_valid = 0; sb2.issue_multi = 0; sb2.issue_fwren = 0; sb2.issue_waddr = 0;
        sb2.issue_frden1 = 0; sb2.issue_frden2 = 0; sb2.issue_frden3 = 0;
        sb2.issue_raddr1 = 0; sb2.issue_raddr2 = 0; sb2.issue_raddr3 = 0;
        sb2.exe_ready = 0; sb2.flush = 0;
    endtask

    task automatic drive_multi(input logic [4:0] wa);
        sb1.issue_valid = 1; sb1.issue_multi = 1; sb1.issue_fwren = 1; sb1.issue_waddr = wa;
    endtask

    task automatic test_reset();
        clr();
        reset = 0;
        sb1.issue_valid = 1; sb1.issue_multi = 1; sb1.issue_frden1 = 1;
        tick(); tick();
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", sb1.stall); end
        n_chk++; if (sb1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", sb1.busy); end
        n_chk++; if (sb1.pend_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", sb1.pend_valid); end
        n_chk++; if (sb1.wb_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wb: got %b want 0", sb1.wb_wren); end
        n_chk++; if (sb1.last_lat !== 8'd0) begin n_fail++; $display("FAIL rst_lat: got %0d want 0", sb1.last_lat); end
        n_chk++; if (sb1.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", sb1.timeout_err); end
        clr();
        reset = 1;
        tick();
    endtask

    task automatic test_fdiv_complete();
        drive_multi(5'd3); #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL fdiv_accept_stall: got %b want 0", sb1.stall); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b1) begin n_fail++; $display("FAIL fdiv_busy: got %b want 1", sb1.busy); end
        n_chk++; if (sb1.pend_valid !== 1'b1 || sb1.pend_waddr !== 5'd3) begin n_fail++; $display("FAIL fdiv_pend: got %b/%0d want 1/3", sb1.pend_valid, sb1.pend_waddr); end
        repeat (9) tick();
        sb1.exe_ready = 1; #1;
        n_chk++; if (sb1.wb_wren !== 1'b1 || sb1.wb_waddr !== 5'd3) begin n_fail++; $display("FAIL fdiv_wb: got %b/%0d want 1/3", sb1.wb_wren, sb1.wb_waddr); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b0) begin n_fail++; $display("FAIL fdiv_idle: busy got %b want 0", sb1.busy); end
        n_chk++; if (sb1.last_lat !== 8'd10) begin n_fail++; $display("FAIL fdiv_lat: got %0d want 10", sb1.last_lat); end
        n_chk++; if (sb1.wb_wren !== 1'b0 || sb1.pend_valid !== 1'b0) begin n_fail++; $display("FAIL fdiv_after: wb/pend got %b/%b want 0/0", sb1.wb_wren, sb1.pend_valid); end
    endtask

    task automatic test_raw_stall();
        drive_multi(5'd3);
        tick(); clr();
        sb1.issue_valid = 1; sb1.issue_fwren = 1; sb1.issue_waddr = 5'd5;
        sb1.issue_frden1 = 1; sb1.issue_raddr1 = 5'd3; #1;
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL raw_src1: stall got %b want 1", sb1.stall); end
        sb1.issue_frden1 = 0; sb1.issue_frden2 = 1; sb1.issue_raddr2 = 5'd3; #1;
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL raw_src2: stall got %b want 1", sb1.stall); end
        sb1.issue_frden2 = 0; sb1.issue_frden3 = 1; sb1.issue_raddr3 = 5'd3; #1;
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL raw_src3: stall got %b want 1", sb1.stall); end
        sb1.issue_frden3 = 0; #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL raw_disabled: stall got %b want 0", sb1.stall); end
        sb1.issue_frden1 = 1; sb1.issue_raddr1 = 5'd1; sb1.issue_frden2 = 1; sb1.issue_raddr2 = 5'd2; #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL raw_indep: stall got %b want 0", sb1.stall); end
        sb1.issue_raddr1 = 5'd3; sb1.exe_ready = 1; #1;
        n_chk++; if (sb1.stall !== 1'b1 || sb1.wb_wren !== 1'b1) begin n_fail++; $display("FAIL raw_exe_cycle: stall/wb got %b/%b want 1/1", sb1.stall, sb1.wb_wren); end
        tick(); sb1.exe_ready = 0; #1;
        n_chk++; if (sb1.stall !== 1'b0 || sb1.busy !== 1'b0) begin n_fail++; $display("FAIL raw_release: stall/busy got %b/%b want 0/0", sb1.stall, sb1.busy); end
        n_chk++; if (sb1.last_lat !== 8'd1) begin n_fail++; $display("FAIL raw_lat: got %0d want 1", sb1.last_lat); end
        clr();
    endtask

    task automatic test_struct_waw();
        drive_multi(5'd3);
        tick(); clr();
        sb1.issue_valid = 1; sb1.issue_multi = 1; sb1.issue_fwren = 1; sb1.issue_waddr = 5'd9; #1;
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL struct: stall got %b want 1", sb1.stall); end
        sb1.issue_multi = 0; sb1.issue_waddr = 5'd3; #1;
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL waw: stall got %b want 1", sb1.stall); end
        sb1.issue_fwren = 0; #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL waw_nowrite: stall got %b want 0", sb1.stall); end
        sb1.issue_valid = 0; sb1.issue_multi = 1; sb1.issue_fwren = 1; #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL struct_novalid: stall got %b want 0", sb1.stall); end
        clr();
        tick();
        sb1.exe_ready = 1; #1;
        n_chk++; if (sb1.wb_wren !== 1'b1 || sb1.wb_waddr !== 5'd3) begin n_fail++; $display("FAIL struct_wb: got %b/%0d want 1/3", sb1.wb_wren, sb1.wb_waddr); end
        tick(); clr(); #1;
        n_chk++; if (sb1.last_lat !== 8'd2) begin n_fail++; $display("FAIL struct_lat: got %0d want 2", sb1.last_lat); end
    endtask

    task automatic test_flush();
        drive_multi(5'd10);
        tick(); clr();
        repeat (3) tick();
        sb1.flush = 1; #1;
        n_chk++; if (sb1.wb_wren !== 1'b0) begin n_fail++; $display("FAIL flush_wb: got %b want 0", sb1.wb_wren); end
        tick(); sb1.flush = 0;
        sb1.issue_valid = 1; sb1.issue_multi = 1; #1;
        n_chk++; if (sb1.busy !== 1'b1 || sb1.pend_valid !== 1'b0) begin n_fail++; $display("FAIL kill_state: busy/pend got %b/%b want 1/0", sb1.busy, sb1.pend_valid); end
        n_chk++; if (sb1.stall !== 1'b1) begin n_fail++; $display("FAIL kill_struct: stall got %b want 1", sb1.stall); end
        clr();
        repeat (4) tick();
        sb1.exe_ready = 1; #1;
        n_chk++; if (sb1.wb_wren !== 1'b0) begin n_fail++; $display("FAIL kill_wb: got %b want 0", sb1.wb_wren); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle: busy got %b want 0", sb1.busy); end
        n_chk++; if (sb1.last_lat !== 8'd2) begin n_fail++; $display("FAIL kill_lat: got %0d want 2", sb1.last_lat); end
        // Flush and completion together: the write must survive.
        drive_multi(5'd12);
        tick(); clr();
        repeat (2) tick();
        sb1.flush = 1; sb1.exe_ready = 1; #1;
        n_chk++; if (sb1.wb_wren !== 1'b1 || sb1.wb_waddr !== 5'd12) begin n_fail++; $display("FAIL flush_exe_wb: got %b/%0d want 1/12", sb1.wb_wren, sb1.wb_waddr); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b0 || sb1.last_lat !== 8'd3) begin n_fail++; $display("FAIL flush_exe_after: busy/lat got %b/%0d want 0/3", sb1.busy, sb1.last_lat); end
        drive_multi(5'd14); sb1.flush = 1; #1;
        n_chk++; if (sb1.stall !== 1'b0) begin n_fail++; $display("FAIL idle_flush_stall: got %b want 0", sb1.stall); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_accept: busy got %b want 0", sb1.busy); end
    endtask

    task automatic test_back_to_back();
        drive_multi(5'd1);
        tick(); clr();
        sb1.exe_ready = 1; drive_multi(5'd2); #1;
        n_chk++; if (sb1.stall !== 1'b1 || sb1.wb_wren !== 1'b1 || sb1.wb_waddr !== 5'd1) begin n_fail++; $display("FAIL b2b_first: stall/wb/addr got %b/%b/%0d want 1/1/1", sb1.stall, sb1.wb_wren, sb1.wb_waddr); end
        tick(); sb1.exe_ready = 0; #1;
        n_chk++; if (sb1.stall !== 1'b0 || sb1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: stall/busy got %b/%b want 0/0", sb1.stall, sb1.busy); end
        tick(); clr(); #1;
        n_chk++; if (sb1.busy !== 1'b1 || sb1.pend_waddr !== 5'd2) begin n_fail++; $display("FAIL b2b_second: busy/addr got %b/%0d want 1/2", sb1.busy, sb1.pend_waddr); end
        sb1.exe_ready = 1;
        tick(); clr();
    endtask

    task automatic test_timeout();
        sb2.exe_ready = 1; #1;
        n_chk++; if (sb2.wb_wren !== 1'b0) begin n_fail++; $display("FAIL idle_exe_wb: got %b want 0", sb2.wb_wren); end
        tick(); clr(); #1;
        n_chk++; if (sb2.busy !== 1'b0 || sb2.last_lat !== 8'd0) begin n_fail++; $display("FAIL idle_exe_state: busy/lat got %b/%0d want 0/0", sb2.busy, sb2.last_lat); end
        sb2.issue_valid = 1; sb2.issue_multi = 1; sb2.issue_fwren = 1; sb2.issue_waddr = 5'd6;
        tick(); clr();
        repeat (7) tick();
        #1;
        n_chk++; if (sb2.busy !== 1'b1 || sb2.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_before: busy/err got %b/%b want 1/0", sb2.busy, sb2.timeout_err); end
        tick(); #1;
        n_chk++; if (sb2.timeout_err !== 1'b1 || sb2.pend_valid !== 1'b0 || sb2.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: err/pend/busy got %b/%b/%b want 1/0/0", sb2.timeout_err, sb2.pend_valid, sb2.busy); end
        n_chk++; if (sb2.wb_wren !== 1'b0) begin n_fail++; $display("FAIL tmo_wb: got %b want 0", sb2.wb_wren); end
        sb2.issue_valid = 1; sb2.issue_multi = 1; sb2.issue_fwren = 1; sb2.issue_waddr = 5'd7; #1;
        n_chk++; if (sb2.stall !== 1'b0) begin n_fail++; $display("FAIL tmo_reaccept_stall: got %b want 0", sb2.stall); end
        tick(); clr(); #1;
        n_chk++; if (sb2.busy !== 1'b1 || sb2.pend_waddr !== 5'd7) begin n_fail++; $display("FAIL tmo_reaccept: busy/addr got %b/%0d want 1/7", sb2.busy, sb2.pend_waddr); end
        sb2.exe_ready = 1; #1;
        n_chk++; if (sb2.wb_wren !== 1'b1) begin n_fail++; $display("FAIL tmo_next_wb: got %b want 1", sb2.wb_wren); end
        tick(); clr(); #1;
        n_chk++; if (sb2.timeout_err !== 1'b1 || sb2.last_lat !== 8'd1) begin n_fail++; $display("FAIL tmo_sticky: err/lat got %b/%0d want 1/1", sb2.timeout_err, sb2.last_lat); end
    endtask

    task automatic test_reset_mid();
        drive_multi(5'd4);
        tick(); clr();
        repeat (2) tick();
        reset = 0;
        tick(); #1;
        n_chk++; if (sb1.busy !== 1'b0 || sb1.pend_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_state: busy/pend got %b/%b want 0/0", sb1.busy, sb1.pend_valid); end
        n_chk++; if (sb1.last_lat !== 8'd0 || sb1.timeout_err !== 1'b0) begin n_fail++; $display("FAIL mrst_outs: lat/err got %0d/%b want 0/0", sb1.last_lat, sb1.timeout_err); end
        n_chk++; if (sb2.timeout_err !== 1'b0) begin n_fail++; $display("FAIL mrst_tmo_clear: got %b want 0", sb2.timeout_err); end
        reset = 1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fdiv_complete();
        test_raw_stall();
        test_struct_waw();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
